// File: rtl/alu_xor_ctrl.sv
// Two-requester arbiter and sequencer for the 8-bit XOR/compare ALU slice, plus the G/E/Z flag register.
// Define ALU_XOR_CTRL_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module alu_xor_ctrl #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [1:0]   op0,
   input  logic [1:0]   op1,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic         ack0,
   output logic         ack1,
   output logic         done0,
   output logic         done1,
   output logic [W-1:0] res,
   output logic         gr_f,
   output logic         eq_f,
   output logic         z_f,
   output logic         err,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_XOR  = 2'b00;
   localparam logic [1:0] OP_CMP  = 2'b01;
   localparam logic [1:0] OP_CLRF = 2'b10;

   state_t         state_q;
   logic           ack0_q, ack1_q, done0_q, done1_q, err_q, busy_q;
   logic [W-1:0]   res_q;
   logic           gr_q, eq_q, z_q;
   logic           owner_q;
`ifdef ALU_XOR_CTRL_RR_EN
   logic           rr_ptr_q;
`endif

   logic [1:0]     op_q;
   logic [W-1:0]   a_q, b_q;

   logic           gnt_vld;
   logic           gnt_idx;
   logic [1:0]     op_d;
   logic [W-1:0]   a_d, b_d;

   logic [W-1:0]   res_d;
   logic           gr_d, eq_d, z_d, err_d;

   // Unsigned magnitude compare scanning from the MSB: the first differing bit decides.
   function automatic logic f_gt(input logic [W-1:0] a, input logic [W-1:0] b);
      logic decided;
      logic gt;
      decided = 1'b0;
      gt      = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!decided && (a[i] != b[i])) begin
            decided = 1'b1;
            gt      = a[i];
         end
      end
      return gt;
   endfunction

   function automatic logic f_is_zero(input logic [W-1:0] v);
      return (v == '0);
   endfunction

   always_comb begin
      gnt_vld = req0 | req1;
`ifdef ALU_XOR_CTRL_RR_EN
      gnt_idx = (req0 && req1) ? rr_ptr_q : req1;
`else
      gnt_idx = ~req0;
`endif
      op_d = gnt_idx ? op1 : op0;
      a_d  = gnt_idx ? a1  : a0;
      b_d  = gnt_idx ? b1  : b0;
   end

   always_comb begin
      res_d = res_q;
      gr_d  = gr_q;
      eq_d  = eq_q;
      z_d   = z_q;
      err_d = 1'b0;
      case (op_q)
         OP_XOR: begin
            res_d = a_q ^ b_q;
            z_d   = f_is_zero(a_q ^ b_q);
         end
         OP_CMP: begin
            gr_d = f_gt(a_q, b_q);
            eq_d = (a_q == b_q);
            z_d  = (a_q == b_q);
         end
         OP_CLRF: begin
            gr_d = 1'b0;
            eq_d = 1'b0;
            z_d  = 1'b0;
         end
         default: err_d = 1'b1;
      endcase
   end

   // Operands are pure data; they are only meaningful after a grant, so they carry no reset.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && gnt_vld) begin
         op_q <= op_d;
         a_q  <= a_d;
         b_q  <= b_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         res_q   <= '0;
         gr_q    <= 1'b0;
         eq_q    <= 1'b0;
         z_q     <= 1'b0;
         owner_q <= 1'b0;
`ifdef ALU_XOR_CTRL_RR_EN
         rr_ptr_q <= 1'b0;
`endif
      end else begin
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (gnt_vld) begin
                  state_q <= S_EXEC;
                  busy_q  <= 1'b1;
                  owner_q <= gnt_idx;
                  ack0_q  <= ~gnt_idx;
                  ack1_q  <= gnt_idx;
`ifdef ALU_XOR_CTRL_RR_EN
                  rr_ptr_q <= ~gnt_idx;
`endif
               end
            end
            S_EXEC: begin
               state_q <= S_DONE;
               res_q   <= res_d;
               gr_q    <= gr_d;
               eq_q    <= eq_d;
               z_q     <= z_d;
               err_q   <= err_d;
               done0_q <= ~owner_q;
               done1_q <= owner_q;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ack0  = ack0_q;
   assign ack1  = ack1_q;
   assign done0 = done0_q;
   assign done1 = done1_q;
   assign res   = res_q;
   assign gr_f  = gr_q;
   assign eq_f  = eq_q;
   assign z_f   = z_q;
   assign err   = err_q;
   assign busy  = busy_q;

endmodule
